tl_ram_responder: RTL and testbench

//  TileLink-UL manager endpoint: terminates the A channel leaving a crossbar

---
 rtl/tl_ram_responder.sv | 212 +++++++++++++++++++++
 tb/tb_tl_ram_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_responder.sv
// TileLink-UL manager endpoint backed by a 64-bit wide local RAM; one transaction in flight.
// Optional TLRAM_DENY_OOR_EN: deny requests whose word offset falls outside the RAM.
module tl_ram_responder #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned MAX_SIZE  = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [2:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [30:0] BASE = 31'(ADDR_BASE);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;

  typedef enum logic [2:0] {StIdle, StPut, StAck, StGet, StErr} state_e;

  state_e          state_q, state_d;
  logic [2:0]      source_q, source_d;
  logic [2:0]      size_q, size_d;
  logic [AW-1:0]   base_q, base_d;
  logic [4:0]      beat_q, beat_d;
  logic            err_data_q, err_data_d;

  logic [63:0]     mem [DEPTH];

  // Number of beats minus one for a transfer of 2^size bytes on a 64-bit bus.
  function automatic logic [4:0] beats_m1(input logic [2:0] size);
    logic [15:0] n;
    if (size <= 3'd3) return 5'd0;
    n = (16'd1 << (size - 3'd3)) - 16'd1;
    return n[4:0];
  endfunction

  // Request decode from the live A-channel beat.
  logic [30:0]   offset;
  logic [27:0]   word_off;
  logic [4:0]    req_m1;
  logic [AW-1:0] req_base;
  logic          op_ok, size_ok, range_ok, req_ok, is_put;

  always_comb begin
    offset   = auto_in_a_bits_address - BASE;
    word_off = offset[30:3];
    req_m1   = beats_m1(auto_in_a_bits_size);
    // Burst base is aligned to the transfer size; low address bits are ignored.
    req_base = word_off[AW-1:0] & ~AW'(req_m1);
    is_put   = (auto_in_a_bits_opcode == OpPutFull) || (auto_in_a_bits_opcode == OpPutPartial);
    op_ok    = is_put || (auto_in_a_bits_opcode == OpGet);
    size_ok  = 32'(auto_in_a_bits_size) <= MAX_SIZE;
`ifdef TLRAM_DENY_OOR_EN
    range_ok = (auto_in_a_bits_address >= BASE) && (32'(word_off) < DEPTH);
`else
    range_ok = 1'b1;
`endif
    req_ok   = op_ok && size_ok && range_ok;
  end

  // RAM write port: byte-lane masked, poisoned beats dropped.
  logic          we;
  logic [AW-1:0] waddr;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    if (state_q == StIdle && auto_in_a_valid && req_ok && is_put) begin
      we    = !auto_in_a_bits_corrupt;
      waddr = req_base;
    end else if (state_q == StPut && auto_in_a_valid) begin
      we    = !auto_in_a_bits_corrupt;
      waddr = base_q + AW'(beat_q);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (we && auto_in_a_bits_mask[i]) begin
        mem[waddr][i*8 +: 8] <= auto_in_a_bits_data[i*8 +: 8];
      end
    end
  end

  logic [AW-1:0] rd_word;
  logic [63:0]   rd_data;

  assign rd_word = base_q + AW'(beat_q);
  assign rd_data = mem[rd_word];

  always_comb begin
    state_d                = state_q;
    source_d               = source_q;
    size_d                 = size_q;
    base_d                 = base_q;
    beat_d                 = beat_q;
    err_data_d             = err_data_q;
    auto_in_a_ready        = 1'b0;
    auto_in_d_valid        = 1'b0;
    auto_in_d_bits_opcode  = 3'd0;
    auto_in_d_bits_denied  = 1'b0;
    auto_in_d_bits_corrupt = 1'b0;
    auto_in_d_bits_data    = '0;
    unique case (state_q)
      StIdle: begin
        auto_in_a_ready = 1'b1;
        if (auto_in_a_valid) begin
          source_d   = auto_in_a_bits_source;
          size_d     = auto_in_a_bits_size;
          base_d     = req_base;
          beat_d     = 5'd0;
          err_data_d = !is_put;
          if (!req_ok) begin
            state_d = StErr;
          end else if (!is_put) begin
            state_d = StGet;
          end else if (req_m1 == 5'd0) begin
            state_d = StAck;
          end else begin
            state_d = StPut;
            beat_d  = 5'd1;
          end
        end
      end
      StPut: begin
        auto_in_a_ready = 1'b1;
        if (auto_in_a_valid) begin
          if (beat_q == beats_m1(size_q)) begin
            state_d = StAck;
            beat_d  = 5'd0;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      StAck: begin
        auto_in_d_valid = 1'b1;
        if (auto_in_d_ready) state_d = StIdle;
      end
      StGet: begin
        auto_in_d_valid       = 1'b1;
        auto_in_d_bits_opcode = 3'd1;
        auto_in_d_bits_data   = rd_data;
        if (auto_in_d_ready) begin
          if (beat_q == beats_m1(size_q)) begin
            state_d = StIdle;
            beat_d  = 5'd0;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      StErr: begin
        // Gets and unknown opcodes answer with poisoned data; Puts with a plain ack.
        auto_in_d_valid        = 1'b1;
        auto_in_d_bits_denied  = 1'b1;
        auto_in_d_bits_opcode  = err_data_q ? 3'd1 : 3'd0;
        auto_in_d_bits_corrupt = err_data_q;
        if (auto_in_d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      source_q   <= '0;
      size_q     <= '0;
      base_q     <= '0;
      beat_q     <= '0;
      err_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      source_q   <= source_d;
      size_q     <= size_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      err_data_q <= err_data_d;
    end
  end

  assign auto_in_d_bits_param  = 2'd0;
  assign auto_in_d_bits_sink   = 1'b0;
  assign auto_in_d_bits_size   = size_q;
  assign auto_in_d_bits_source = source_q;

  logic unused_bits;
  assign unused_bits = ^{auto_in_a_bits_param, offset[2:0], word_off};

endmodule

// File: tb/tb_tl_ram_responder.sv
// Randomized self-checking bench for tl_ram_responder against a word-array memory model.
module tb_tl_ram_responder;

  localparam int unsigned DEPTH     = 512;
  localparam int unsigned ADDR_BASE = 0;
  localparam int unsigned MAX_SIZE  = 6;

  logic        clock;
  logic        reset;
  logic        a_ready, a_valid;
  logic [2:0]  a_opcode, a_param, a_size, a_source;
  logic [30:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_ready, d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size, d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [63:0] d_data;

  tl_ram_responder #(
    .DEPTH     (DEPTH),
    .ADDR_BASE (ADDR_BASE),
    .MAX_SIZE  (MAX_SIZE)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wbuf  [8];

  function automatic int unsigned beats_of(input logic [2:0] size);
    return (size <= 3'd3) ? 1 : (1 << (int'(size) - 3));
  endfunction

  function automatic int unsigned word_offset(input logic [30:0] addr);
    return ((32'(addr) - ADDR_BASE) & 32'h7FFF_FFFF) / 8;
  endfunction

  function automatic bit legal(input logic [2:0] op, input logic [2:0] size,
                               input logic [30:0] addr);
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
    if (int'(size) > int'(MAX_SIZE)) return 1'b0;
`ifdef TLRAM_DENY_OOR_EN
    if (32'(addr) < ADDR_BASE) return 1'b0;
    if (word_offset(addr) >= DEPTH) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int unsigned base_word(input logic [30:0] addr, input logic [2:0] size);
    int unsigned w;
    w = word_offset(addr);
    w = w - (w % beats_of(size));
    return w % DEPTH;
  endfunction

  // Full transaction: A beats from wbuf, then every D cycle checked against the model.
  task automatic do_txn(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                        input logic [30:0] addr, input logic [7:0] mask,
                        input logic [7:0] corrupt, input int ready_mode,
                        output logic [63:0] rdata0);
    int unsigned nb   = beats_of(size);
    bit          ok   = legal(op, size, addr);
    bit          put  = (op == 3'd0) || (op == 3'd1);
    int unsigned na   = (put && ok) ? nb : 1;
    int unsigned w0   = base_word(addr, size);
    logic [74:0] exp_q[$];
    logic [74:0] got;
    logic [2:0]  eop;
    int          beat;
    int          guard;
    for (int b = 0; b < int'(na); b++) begin
      if (b > 0 && $urandom_range(3) == 0) begin
        @(posedge clock);
        #1;
      end
      a_opcode  = op;
      a_param   = 3'($urandom_range(7));
      a_size    = size;
      a_source  = src;
      a_address = addr;
      a_mask    = mask;
      a_data    = wbuf[b];
      a_corrupt = corrupt[b];
      a_valid   = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (a_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL a_ready beat %0d: got %b want 1", b, a_ready);
      end
      @(posedge clock);
      #1;
      a_valid = 1'b0;
      if (put && ok && !corrupt[b]) begin
        for (int i = 0; i < 8; i++) begin
          if (mask[i]) model[(w0 + b) % DEPTH][i*8 +: 8] = wbuf[b][i*8 +: 8];
        end
      end
    end
    if (!ok) begin
      eop = put ? 3'd0 : 3'd1;
      exp_q.push_back({eop, 1'b1, !put, src, size, 64'd0});
    end else if (put) begin
      exp_q.push_back({3'd0, 1'b0, 1'b0, src, size, 64'd0});
    end else begin
      for (int b = 0; b < int'(nb); b++) begin
        exp_q.push_back({3'd1, 1'b0, 1'b0, src, size, model[(w0 + b) % DEPTH]});
      end
    end
    beat    = 0;
    guard   = 0;
    rdata0  = '0;
    d_ready = (ready_mode == 1) ? 1'b0 : 1'($urandom_range(1));
    while (beat < exp_q.size() && guard < 200) begin
      @(negedge clock);
      guard++;
      n_cmp++;
      if (d_valid !== 1'b1 || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL d_handshake beat %0d: d_valid=%b a_ready=%b want 1/0",
                 beat, d_valid, a_ready);
      end else begin
        got = {d_opcode, d_denied, d_corrupt, d_source, d_size, d_data};
        n_cmp++;
        if (got !== exp_q[beat]) begin
          n_fail++;
          $display("FAIL d_beat %0d op %0d: got %h want %h", beat, op, got, exp_q[beat]);
        end
        if (beat == 0) rdata0 = d_data;
        if (d_ready) beat++;
      end
      @(posedge clock);
      #1;
      d_ready = (ready_mode == 1) ? !d_ready : 1'($urandom_range(1));
    end
    if (beat < exp_q.size()) begin
      n_fail++;
      $display("FAIL d_timeout: got %0d beats want %0d", beat, exp_q.size());
    end
    d_ready = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after: d_valid=%b a_ready=%b want 0/1", d_valid, a_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: a_ready=%b d_valid=%b want 1/0", a_ready, d_valid);
    end
    n_cmp++;
    if (d_source !== 3'd0 || d_size !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_latched: source=%0d size=%0d want 0/0", d_source, d_size);
    end
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    n_cmp++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: a_ready=%b d_valid=%b want 1/0", a_ready, d_valid);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_init_fill();
    logic [63:0] r;
    for (int w = 0; w < int'(DEPTH); w += 8) begin
      for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
      do_txn(3'd0, 3'd6, 3'(w % 8), 31'(ADDR_BASE + w * 8), 8'hFF, 8'h00, 0, r);
    end
  endtask

  task automatic test_put_get();
    logic [63:0] r;
    wbuf[0] = 64'hDEADBEEF_01234567;
    do_txn(3'd0, 3'd3, 3'd2, 31'(ADDR_BASE + 32'h10), 8'hFF, 8'h00, 0, r);
    do_txn(3'd4, 3'd3, 3'd6, 31'(ADDR_BASE + 32'h10), 8'h00, 8'h00, 0, r);
    n_cmp++;
    if (r !== 64'hDEADBEEF_01234567) begin
      n_fail++;
      $display("FAIL put_get_data: got %h want deadbeef01234567", r);
    end
  endtask

  task automatic test_partial();
    logic [63:0] r;
    wbuf[0] = 64'h11223344_55667788;
    do_txn(3'd0, 3'd3, 3'd1, 31'(ADDR_BASE + 32'h20), 8'hFF, 8'h00, 0, r);
    wbuf[0] = 64'hFFFFFFFF_FFFFFFFF;
    do_txn(3'd1, 3'd3, 3'd1, 31'(ADDR_BASE + 32'h20), 8'h0F, 8'h00, 0, r);
    do_txn(3'd4, 3'd3, 3'd7, 31'(ADDR_BASE + 32'h20), 8'h00, 8'h00, 0, r);
    n_cmp++;
    if (r !== 64'h11223344_FFFFFFFF) begin
      n_fail++;
      $display("FAIL partial_data: got %h want 11223344ffffffff", r);
    end
  endtask

  task automatic test_burst_stall();
    logic [63:0] r;
    do_txn(3'd4, 3'd6, 3'd3, 31'(ADDR_BASE + 32'h40), 8'h00, 8'h00, 1, r);
    n_cmp++;
    if (r !== model[8]) begin
      n_fail++;
      $display("FAIL burst_first_word: got %h want %h", r, model[8]);
    end
  endtask

  task automatic test_errors();
    logic [63:0] r;
    do_txn(3'd2, 3'd3, 3'd5, 31'(ADDR_BASE), 8'hFF, 8'h00, 0, r);
    do_txn(3'd4, 3'd7, 3'd5, 31'(ADDR_BASE), 8'h00, 8'h00, 0, r);
    wbuf[0] = 64'h0BAD_0BAD_0BAD_0BAD;
    do_txn(3'd0, 3'd7, 3'd4, 31'(ADDR_BASE), 8'hFF, 8'h00, 0, r);
    do_txn(3'd4, 3'd3, 3'd4, 31'(ADDR_BASE), 8'h00, 8'h00, 0, r);
  endtask

  task automatic test_oor();
    logic [63:0] r;
    do_txn(3'd4, 3'd3, 3'd4, 31'(ADDR_BASE + DEPTH * 8), 8'h00, 8'h00, 0, r);
  endtask

  task automatic test_corrupt();
    logic [63:0] r;
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    wbuf[1] = 64'h5555_5555_5555_5555;
    do_txn(3'd0, 3'd4, 3'd2, 31'(ADDR_BASE + 32'h80), 8'hFF, 8'h01, 0, r);
    do_txn(3'd4, 3'd4, 3'd2, 31'(ADDR_BASE + 32'h80), 8'h00, 8'h00, 0, r);
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [2:0]  op, size;
    int          pick;
    for (int t = 0; t < 150; t++) begin
      pick = $urandom_range(9);
      if (pick <= 2) op = 3'd0;
      else if (pick <= 4) op = 3'd1;
      else if (pick <= 8) op = 3'd4;
      else op = 3'($urandom_range(1) ? 2 : ($urandom_range(1) ? 5 : 7));
      size = ($urandom_range(15) == 0) ? 3'd7 : 3'($urandom_range(6));
      for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
      do_txn(op, size, 3'($urandom_range(7)), 31'(ADDR_BASE + $urandom_range(DEPTH * 16 - 1)),
             8'($urandom_range(255)),
             ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'h00, 0, r);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] r;
    for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
    for (int b = 0; b < 3; b++) begin
      a_opcode = 3'd0; a_size = 3'd6; a_source = 3'd1; a_address = 31'(ADDR_BASE + 32'h100);
      a_mask = 8'hFF; a_data = wbuf[b]; a_corrupt = 1'b0; a_valid = 1'b1;
      @(posedge clock);
      #1;
      model[32 + b] = wbuf[b];
    end
    a_data = wbuf[3];
    @(negedge clock);
    #2;
    reset   = 1'b0;
    a_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: a_ready=%b d_valid=%b want 1/0", a_ready, d_valid);
    end
    @(posedge clock);
    #1;
    do_txn(3'd4, 3'd6, 3'd2, 31'(ADDR_BASE + 32'h100), 8'h00, 8'h00, 0, r);
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_put_get();
    test_partial();
    test_burst_stall();
    test_errors();
    test_oor();
    test_corrupt();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
